bcd_timer_ctrl: RTL and testbench
=================================

Name: bcd_timer_ctrl

Overview:
- Control stage that drives a two-digit BCD down counter (99..0, loadN/ena/ena_cnt inputs, countH/countL/tc outputs) used as the game countdown timer.
- Generates the one-second count-enable tick, the load pulse and the enable.
- Runs a start/pause/restart state machine.
- Consumes the counter's digits and tc to produce time-up, running and low-time warning-blink signals for game logic and display.

Parameters:
- ONE_SEC_CNT, 50_000_000, clk cycles per count tick; legal range >= 2.
- WARN_H, 4'h1, warning threshold tens digit (BCD).
- WARN_L, 4'h0, warning threshold units digit (BCD).
- BLINK_DIV, 12_500_000, clk cycles per warn_blink toggle; legal range >= 1.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- start  in  1  level; in IDLE, begins a load and run
- pause_req  in  1  one-cycle pulse; toggles RUN <-> PAUSE
- restart  in  1  one-cycle pulse; reload from any state
- countH  in  4  counter tens digit
- countL  in  4  counter units digit
- tc  in  1  counter terminal count; high when counter reads 00
- loadN  out  1  active-low load strobe to the counter
- ena  out  1  counter enable
- ena_cnt  out  1  one-cycle count-down strobe to the counter
- running  out  1  high in RUN
- time_up  out  1  one-cycle pulse on expiry
- expired  out  1  level; high in EXPIRED
- warn_blink  out  1  low-time blink for display

Behaviour:
- All outputs registered.
- Reset (async, resetN=0), from any state including mid-run: state=IDLE, prescaler=0, blink counter=0, loadN=1, ena=0, ena_cnt=0, running=0, time_up=0, expired=0, warn_blink=0.
- States: IDLE, LOAD, RUN, PAUSE, EXPIRED.
- Priority: restart > pause_req > start/tick/tc.
- IDLE: ena=0, loadN=1.
  - start=1 -> LOAD.
  - pause_req ignored.
- LOAD: exactly one cycle. loadN=0, ena=1, ena_cnt=0, prescaler cleared. Next state RUN.
- RUN: ena=1, running=1.
  - Prescaler counts 0..ONE_SEC_CNT-1 and wraps.
  - On the wrap cycle, ena_cnt=1 for exactly one cycle, but only if tc=0. ena_cnt is never asserted while tc=1, so the counter does not wrap 00->99.
  - tc=1 sampled in RUN -> EXPIRED. time_up=1 during the first EXPIRED cycle only.
  - Latency: tc high at edge n gives time_up high after edge n+1.
  - tc takes priority over a coincident tick.
  - pause_req -> PAUSE.
- PAUSE: ena=1, ena_cnt=0, running=0.
  - Prescaler frozen (not cleared), so on resume the partial second continues.
  - pause_req -> RUN.
- EXPIRED: ena=0, ena_cnt=0, expired=1, warn_blink=1 steady.
  - Only restart (or reset) leaves this state.
- restart in any state -> LOAD on the next edge. restart with coincident pause_req: pause_req is discarded.
- start held high after LOAD has no further effect.
- Loaded value 00: the first RUN cycle sees tc=1 -> EXPIRED with no ena_cnt.
- Warning:
  - warn_active = (RUN or PAUSE) and {countH,countL} <= {WARN_H,WARN_L}, using an 8-bit unsigned compare, which is valid for legal BCD.
  - While warn_active, warn_blink toggles every BLINK_DIV cycles, starting high on the first warn_active cycle.
  - In IDLE and LOAD, warn_blink=0 and the blink counter is cleared.
  - The blink counter is frozen in PAUSE.

Optional Feature:
- Macro: TIMER_AUTO_RESTART_EN.
- Defined: EXPIRED holds for ONE_SEC_CNT cycles, counted by the prescaler cleared on entry, then moves to LOAD automatically. restart still takes priority. time_up behaviour is unchanged.
- Undefined: EXPIRED is held until restart or reset. No auto-restart logic is synthesized.

Test Plan:
(Bench instantiates the real BCD counter with datain 0x12; ONE_SEC_CNT=4, BLINK_DIV=2.)
1. Run to expiry:
   - Stimulus: reset, then start=1.
   - Response: loadN low exactly 1 cycle; counter reads 12; ena_cnt pulses every 4 cycles; 12 pulses total reach 00.
   - Response: time_up high 1 cycle; expired=1; no further ena_cnt; counter stays 00 for 50 cycles.
2. Pause and resume:
   - Stimulus: pause_req when counter=07, 1 cycle after a tick; hold 20 cycles; then pause_req again.
   - Response: no ena_cnt during pause; counter stays 07; after resume the next ena_cnt comes 3 cycles later; running tracks RUN/PAUSE.
3. Warning blink:
   - Response: warn_blink=0 at 11; at 10 warn_blink goes high, then toggles every 2 cycles; steady 1 after expiry; 0 after restart, during LOAD.
4. Restart priority:
   - Stimulus: restart and pause_req in the same cycle during PAUSE at 05.
   - Response: LOAD next cycle; counter reads 12; state RUN, not PAUSE.
5. Reset mid-run:
   - Stimulus: resetN=0 asynchronously at count 08, between clock edges.
   - Response: all outputs take reset values immediately; state IDLE; no ena_cnt after release until start.
6. Auto-restart:
   - Stimulus: TIMER_AUTO_RESTART_EN defined; run to expiry.
   - Response: after 4 EXPIRED cycles, loadN pulses low; counter reloads 12 and counting resumes.
   - Undefined: expired stays 1 for 100 cycles.

Source files
------------

// File: rtl/bcd_timer_ctrl.sv
// Control stage for a two-digit BCD countdown timer: tick prescaler, load/enable, start/pause/restart FSM, warning blink.
// Optional: define TIMER_AUTO_RESTART_EN to reload automatically one tick period after expiry.
module bcd_timer_ctrl #(
  parameter int         ONE_SEC_CNT = 50_000_000,
  parameter logic [3:0] WARN_H      = 4'h1,
  parameter logic [3:0] WARN_L      = 4'h0,
  parameter int         BLINK_DIV   = 12_500_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       pause_req,
  input  logic       restart,
  input  logic [3:0] countH,
  input  logic [3:0] countL,
  input  logic       tc,
  output logic       loadN,
  output logic       ena,
  output logic       ena_cnt,
  output logic       running,
  output logic       time_up,
  output logic       expired,
  output logic       warn_blink
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, EXPIRED} state_t;

  localparam int PW = $clog2(ONE_SEC_CNT);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(ONE_SEC_CNT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t        state, state_n;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          warn_started;
  logic          presc_wrap;
  logic          warn_active;

  assign presc_wrap  = (presc == PRESC_LAST);
  assign warn_active = ((state == RUN) || (state == PAUSE)) &&
                       ({countH, countL} <= {WARN_H, WARN_L});

  // NOTE: state_n gets its default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    if (restart) begin
      state_n = LOAD;
    end else begin
      case (state)
        IDLE:    if (start) state_n = LOAD;
        LOAD:    state_n = RUN;
        RUN: begin
          if (pause_req) state_n = PAUSE;
          else if (tc)   state_n = EXPIRED;
        end
        PAUSE:   if (pause_req) state_n = RUN;
        EXPIRED: begin
`ifdef TIMER_AUTO_RESTART_EN
          if (presc_wrap) state_n = LOAD;
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Prescaler freezes in PAUSE (and on the pause edge itself) so the partial second resumes intact.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      presc <= '0;
    end else if (state == LOAD || state_n == LOAD) begin
      presc <= '0;
    end else if (state == RUN && state_n == RUN) begin
      presc <= presc_wrap ? '0 : presc + PW'(1);
`ifdef TIMER_AUTO_RESTART_EN
    end else if (state_n == EXPIRED) begin
      presc <= (state == EXPIRED) ? presc + PW'(1) : '0;
`endif
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      loadN   <= 1'b1;
      ena     <= 1'b0;
      ena_cnt <= 1'b0;
      running <= 1'b0;
      time_up <= 1'b0;
      expired <= 1'b0;
    end else begin
      loadN   <= (state_n != LOAD);
      ena     <= (state_n inside {LOAD, RUN, PAUSE});
      // Staying in RUN already excludes tc, pause_req and restart, so 00 never wraps to 99.
      ena_cnt <= (state == RUN) && (state_n == RUN) && presc_wrap;
      running <= (state_n == RUN);
      time_up <= (state == RUN) && (state_n == EXPIRED);
      expired <= (state_n == EXPIRED);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      warn_blink   <= 1'b0;
      blink_cnt    <= '0;
      warn_started <= 1'b0;
    end else if (state_n == EXPIRED) begin
      warn_blink   <= 1'b1;
      blink_cnt    <= '0;
      warn_started <= 1'b0;
    end else if (!warn_active || state_n == IDLE || state_n == LOAD) begin
      warn_blink   <= 1'b0;
      blink_cnt    <= '0;
      warn_started <= 1'b0;
    end else if (!warn_started) begin
      warn_blink   <= 1'b1;
      blink_cnt    <= '0;
      warn_started <= 1'b1;
    end else if (state == RUN) begin
      if (blink_cnt == BLINK_LAST) begin
        warn_blink <= ~warn_blink;
        blink_cnt  <= '0;
      end else begin
        blink_cnt  <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl driving a behavioural two-digit BCD down counter loaded with 0x12.
// Counter values are checked by a scoreboard queue filled when a run is launched.
module tb_bcd_timer_ctrl;

  localparam int ONE_SEC = 4;
  localparam int BLINK   = 2;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic       pause_req = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] countH, countL;
  logic       tc;
  logic       loadN, ena, ena_cnt, running, time_up, expired, warn_blink;

  logic [7:0] cnt = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       pend = 1'b0;
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign countH = cnt[7:4];
  assign countL = cnt[3:0];
  assign tc     = (cnt == 8'h00);

  always @(posedge clk) begin
    if (!loadN)
      cnt <= 8'h12;
    else if (ena && ena_cnt)
      cnt <= (cnt[3:0] == 4'd0) ? {cnt[7:4] - 4'd1, 4'd9} : cnt - 8'd1;
  end

  bcd_timer_ctrl #(
    .ONE_SEC_CNT(ONE_SEC),
    .WARN_H     (4'h1),
    .WARN_L     (4'h0),
    .BLINK_DIV  (BLINK)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .start     (start),
    .pause_req (pause_req),
    .restart   (restart),
    .countH    (countH),
    .countL    (countL),
    .tc        (tc),
    .loadN     (loadN),
    .ena       (ena),
    .ena_cnt   (ena_cnt),
    .running   (running),
    .time_up   (time_up),
    .expired   (expired),
    .warn_blink(warn_blink)
  );

  // Scoreboard: after every load strobe or count strobe the counter must show the next queued value.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        pend = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow: counter=%h with nothing expected", cnt);
        end else begin
          mon_exp = exp_q.pop_front();
          if (cnt !== mon_exp) begin
            errors++;
            $display("FAIL scoreboard_count: counter=%h expected=%h", cnt, mon_exp);
          end
        end
      end
      if (ena_cnt && cnt == 8'h00) begin
        checks++;
        errors++;
        $display("FAIL no_wrap: ena_cnt=1 while counter=00, expected ena_cnt=0");
      end
      if (!loadN || ena_cnt) pend = 1'b1;
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic push_run();
    exp_q.delete();
    for (int v = 12; v >= 0; v--) exp_q.push_back(to_bcd(v));
  endtask

  task automatic wait_cnt(input logic [7:0] v, input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cnt == v) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: counter=%h never reached expected=%h", name, cnt, v);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({loadN, ena, ena_cnt, running, time_up, expired, warn_blink} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_values: outputs=%b expected=1000000",
               {loadN, ena, ena_cnt, running, time_up, expired, warn_blink});
    end
    resetN = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    pause_req = 1'b1;
    @(negedge clk);
    pause_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({loadN, ena, ena_cnt, running} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_hold: loadN/ena/ena_cnt/running=%b expected=1000",
               {loadN, ena, ena_cnt, running});
    end
  endtask

  task automatic test_run_to_expiry();
    int s = 0, load_s = -1, load_low = 0, first_tick = -1, last_tick = -1;
    int ticks = 0, bad_gap = 0, zero_s = -1, tu_s = -1, tu_cnt = 0, exp_s = -1, bad_post = 0;
    push_run();
    start = 1'b1;
    while (exp_s < 0 && s < 150) begin
      @(negedge clk);
      s++;
      if (!loadN) begin
        load_low++;
        if (load_s < 0) load_s = s;
      end
      if (ena_cnt) begin
        ticks++;
        if (last_tick >= 0 && s - last_tick != ONE_SEC) bad_gap++;
        if (first_tick < 0) first_tick = s;
        last_tick = s;
      end
      if (load_s >= 0 && s > load_s && cnt == 8'h00 && zero_s < 0) zero_s = s;
      if (time_up) begin
        tu_cnt++;
        if (tu_s < 0) tu_s = s;
      end
      if (expired && exp_s < 0) exp_s = s;
    end
    checks++;
    if (exp_s < 0) begin
      errors++;
      $display("FAIL expiry_timeout: expired=%b after %0d cycles, expected 1", expired, s);
    end
    repeat (50) begin
      @(negedge clk);
      if (!loadN) load_low++;
      if (time_up) tu_cnt++;
      if (ena_cnt || cnt !== 8'h00 || !expired) bad_post++;
    end
    start = 1'b0;
    checks++;
    if (load_low != 1) begin errors++; $display("FAIL load_width: loadN low %0d cycles, expected 1", load_low); end
    checks++;
    if (first_tick - load_s != 5) begin errors++; $display("FAIL first_tick: %0d cycles after load, expected 5", first_tick - load_s); end
    checks++;
    if (ticks != 12) begin errors++; $display("FAIL tick_total: %0d ticks, expected 12", ticks); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL tick_period: %0d bad gaps, expected 0", bad_gap); end
    checks++;
    if (tu_s != zero_s + 1) begin errors++; $display("FAIL time_up_latency: time_up at %0d, expected %0d", tu_s, zero_s + 1); end
    checks++;
    if (exp_s != tu_s) begin errors++; $display("FAIL expired_align: expired at %0d, expected %0d", exp_s, tu_s); end
    checks++;
    if (tu_cnt != 1) begin errors++; $display("FAIL time_up_width: %0d cycles, expected 1", tu_cnt); end
    checks++;
    if (bad_post != 0) begin errors++; $display("FAIL expired_hold: %0d bad cycles, expected 0", bad_post); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_warn_blink();
    int k = -1, done = 0, n = 0;
    logic exp_b;
    push_run();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++;
    if ({loadN, warn_blink, expired} !== 3'b000) begin
      errors++;
      $display("FAIL load_clears_blink: loadN/warn_blink/expired=%b expected=000", {loadN, warn_blink, expired});
    end
    while (done < 3 && n < 150) begin
      @(negedge clk);
      n++;
      if (k < 0 && cnt == 8'h10) k = 0;
      else if (k >= 0) k++;
      if (expired) exp_b = 1'b1;
      else if (k <= 0) exp_b = 1'b0;
      else exp_b = (((k - 1) / 2) % 2) == 0;
      checks++;
      if (warn_blink !== exp_b) begin
        errors++;
        $display("FAIL warn_blink: counter=%h step=%0d got=%b expected=%b", cnt, k, warn_blink, exp_b);
      end
      if (expired) done++;
    end
    checks++;
    if (done < 3) begin errors++; $display("FAIL warn_timeout: expired=%b, expected 1", expired); end
  endtask

  task automatic test_pause();
    bit ok;
    int hold_bad = 0, n = 0;
    logic wb;
    push_run();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_cnt(8'h07, 100, "pause_reach_07", ok);
    if (ok) begin
      pause_req = 1'b1;
      @(negedge clk);
      pause_req = 1'b0;
      checks++;
      if ({running, ena} !== 2'b01) begin
        errors++;
        $display("FAIL pause_entry: running/ena=%b expected=01", {running, ena});
      end
      wb = warn_blink;
      repeat (20) begin
        @(negedge clk);
        if (ena_cnt || cnt !== 8'h07 || running || !ena || warn_blink !== wb) hold_bad++;
      end
      checks++;
      if (hold_bad != 0) begin errors++; $display("FAIL pause_hold: %0d bad cycles, expected 0", hold_bad); end
      pause_req = 1'b1;
      @(negedge clk);
      pause_req = 1'b0;
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL resume_running: running=%b expected=1", running); end
      while (!ena_cnt && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n != 3) begin errors++; $display("FAIL resume_tick_delay: %0d cycles, expected 3", n); end
    end
  endtask

  task automatic test_restart_priority();
    bit ok;
    wait_cnt(8'h05, 100, "restart_reach_05", ok);
    if (ok) begin
      pause_req = 1'b1;
      @(negedge clk);
      pause_req = 1'b0;
      repeat (3) @(negedge clk);
      push_run();
      restart = 1'b1;
      pause_req = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      pause_req = 1'b0;
      checks++;
      if (loadN !== 1'b0) begin errors++; $display("FAIL restart_load: loadN=%b expected=0", loadN); end
      @(negedge clk);
      checks++;
      if (cnt !== 8'h12 || running !== 1'b1) begin
        errors++;
        $display("FAIL restart_runs: counter=%h running=%b expected=12/1", cnt, running);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({running, ena} !== 2'b11) begin
        errors++;
        $display("FAIL restart_not_paused: running/ena=%b expected=11", {running, ena});
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int bad = 0;
    wait_cnt(8'h08, 100, "reset_reach_08", ok);
    if (ok) begin
      #2 resetN = 1'b0;
      #1;
      checks++;
      if ({loadN, ena, ena_cnt, running, time_up, expired, warn_blink} !== 7'b1000000) begin
        errors++;
        $display("FAIL async_reset: outputs=%b expected=1000000",
                 {loadN, ena, ena_cnt, running, time_up, expired, warn_blink});
      end
      @(negedge clk);
      resetN = 1'b1;
      exp_q.delete();
      repeat (20) begin
        @(negedge clk);
        if (ena_cnt || ena || running || cnt !== 8'h08) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL post_reset_idle: %0d bad cycles, expected 0", bad); end
    end
  endtask

  task automatic test_expiry_hold();
    int n = 0, bad = 0;
    bit ok;
    push_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!expired && n < 120) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!expired) begin errors++; $display("FAIL hold_expiry_timeout: expired=%b expected=1", expired); end
`ifdef TIMER_AUTO_RESTART_EN
    push_run();
    n = 0;
    while (loadN && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL auto_restart_delay: loadN low after %0d cycles, expected 4", n); end
    wait_cnt(8'h11, 40, "auto_restart_counting", ok);
`else
    repeat (100) begin
      @(negedge clk);
      if (!expired || !loadN || ena_cnt) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL expired_held: %0d bad cycles, expected 0", bad); end
`endif
  endtask

  initial begin
    test_reset();
    test_run_to_expiry();
    test_warn_blink();
    test_pause();
    test_restart_priority();
    test_reset_mid_run();
    test_expiry_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
